// File: rtl/poly_operand_sender.sv
// poly_operand_sender
//
// Initiator for the Go/DataIn operand-load protocol of the polynomial
// evaluator (result = A*X^2 + B*X + C mod 256). One Start pulse captures the
// four operands. They are then presented in the order A, B, C, X as
// press/release Go handshakes with DataIn held stable. The block then waits
// for ResultValid, captures DataResult and pulses Done. If the evaluator
// never answers, the wait times out and Error is raised instead.
//
// Parameters:
//   HOLD     cycles Go stays high per operand (>= 1)
//   GAP      cycles Go stays low after each release (>= 1)
//   TIMEOUT  cycles allowed while waiting for the result (>= 8)
//
// Ports:
//   Clock        sole clock, rising edge
//   Resetn       asynchronous active-low reset
//   Start        begin a transaction (sampled only when idle)
//   A, B, C, X   8-bit operands, captured on the accepted Start edge
//   Go           handshake strobe to the evaluator
//   DataIn       8-bit operand bus to the evaluator
//   ResultValid  evaluator result-ready flag (only looked at while waiting)
//   DataResult   8-bit evaluator result
//   Busy         high whenever a transaction is in progress
//   Done         one-cycle pulse at the end of a transaction
//   Error        timeout flag, sticky until the next accepted Start
//   Result       last captured DataResult
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.

module poly_operand_sender #(
    parameter int HOLD    = 2,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 64
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] C,
    input  logic [7:0] X,
    output logic       Go,
    output logic [7:0] DataIn,
    input  logic       ResultValid,
    input  logic [7:0] DataResult,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [7:0] Result
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PRESS,
        RELEASE,
        WAIT_RES,
        DONE
    } state_t;

    // One shared cycle counter serves PRESS, RELEASE and WAIT_RES. It is
    // sized for the largest of the three limits and saturates at all-ones.
    localparam int MAX_HG  = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAX_CNT = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [7:0]      operand [4];
    logic [1:0]      index;
    logic [1:0]      next_index;
    logic [CW-1:0]   count;
    logic            counting;
    logic            capture_result;
    logic            timeout_hit;
    logic [7:0]      data_in_q;
    logic [7:0]      result_q;
    logic            error_q;

    assign next_index = index + 2'd1;
    assign counting   = (state == PRESS) || (state == RELEASE) || (state == WAIT_RES);

    // Next-state decode. ResultValid only matters in WAIT_RES; a stale flag
    // seen in any other state is deliberately ignored. When the result and
    // the timeout coincide, the result wins and no error is flagged.
    always_comb begin
        state_next     = state;
        capture_result = 1'b0;
        timeout_hit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = PRESS;
            end
            PRESS: begin
                if (count == HOLD_LAST) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (count == GAP_LAST) begin
                    state_next = (index == 2'd3) ? WAIT_RES : SETUP;
                end
            end
            WAIT_RES: begin
                if (ResultValid) begin
                    capture_result = 1'b1;
                    state_next     = DONE;
                end else if (count == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath. DataIn is only ever reloaded on entry to
    // SETUP, which gives the evaluator one full cycle of setup before Go
    // rises and keeps the bus stable through the whole press/release.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            operand[0] <= 8'd0;
            operand[1] <= 8'd0;
            operand[2] <= 8'd0;
            operand[3] <= 8'd0;
            index      <= 2'd0;
            count      <= '0;
            data_in_q  <= 8'd0;
            result_q   <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                count <= '0;
            end else if (counting && (count != '1)) begin
                count <= count + 1'b1;
            end

            if ((state == IDLE) && Start) begin
                operand[0] <= A;
                operand[1] <= B;
                operand[2] <= C;
                operand[3] <= X;
                index      <= 2'd0;
                error_q    <= 1'b0;
                data_in_q  <= A;
            end

            if ((state == RELEASE) && (state_next == SETUP)) begin
                index     <= next_index;
                data_in_q <= operand[next_index];
            end

            if (capture_result) begin
                result_q <= DataResult;
            end

            if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign Go     = (state == PRESS);
    assign Busy   = (state != IDLE);
    assign Done   = (state == DONE);
    assign DataIn = data_in_q;
    assign Error  = error_q;
    assign Result = result_q;

endmodule

// File: tb/tb_poly_operand_sender.sv
// tb_poly_operand_sender
//
// Two lanes, each with its own poly_operand_sender instance and its own
// behavioural evaluator: lane 0 uses the default timing (HOLD=2, GAP=1,
// TIMEOUT=64) and lane 1 uses HOLD=1, GAP=3, TIMEOUT=16. Each lane's
// stimulus pushes the expected operand sequence and the expected completion
// (result, error, latency from the final Go fall) into queues; a monitor
// running on the falling clock edge pops and compares whenever Go rises or
// Done pulses.

module tb_poly_operand_sender;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
    } exp_t;

    // The evaluator needs one edge to notice the final Go fall, then
    // COMPUTE edges to produce ResultValid, then the sender needs one more
    // edge to sample it.
    localparam int COMPUTE = 5;

    function automatic logic [7:0] poly(input logic [7:0] pa, input logic [7:0] pb,
                                        input logic [7:0] pc, input logic [7:0] px);
        int r;
        r = int'(pa) * int'(px) * int'(px) + int'(pb) * int'(px) + int'(pc);
        return 8'(r);
    endfunction

    task automatic check(input string name, input int lane_id, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL lane%0d %s: got %0d expected %0d", lane_id, name, got, want);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LH = (g == 0) ? 2 : 1;
        localparam int LG = (g == 0) ? 1 : 3;
        localparam int LT = (g == 0) ? 64 : 16;
        localparam int PERIOD = 1 + LH + LG;
        localparam int FINAL_FALL = 3 * PERIOD + 1 + LH;

        logic       resetn = 1'b1;
        logic       start = 1'b0;
        logic [7:0] a = 8'd0;
        logic [7:0] b = 8'd0;
        logic [7:0] c = 8'd0;
        logic [7:0] x = 8'd0;
        logic       go;
        logic [7:0] data_in;
        logic       rv;
        logic [7:0] data_result;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] result;
        logic       finished = 1'b0;

        exp_t       exp_q[$];
        logic [7:0] exp_ops[$];
        logic [7:0] last_res = 8'd0;

        // Evaluator model controls.
        logic       eval_mute = 1'b0;
        logic       force_rv = 1'b0;
        logic       eval_rv;
        logic       eval_go_q;
        logic [7:0] eval_cap [4];
        int         eval_n;
        int         eval_cd;

        assign rv = eval_rv | force_rv;

        poly_operand_sender #(
            .HOLD   (LH),
            .GAP    (LG),
            .TIMEOUT(LT)
        ) dut (
            .Clock      (clock),
            .Resetn     (resetn),
            .Start      (start),
            .A          (a),
            .B          (b),
            .C          (c),
            .X          (x),
            .Go         (go),
            .DataIn     (data_in),
            .ResultValid(rv),
            .DataResult (data_result),
            .Busy       (busy),
            .Done       (done),
            .Error      (err),
            .Result     (result)
        );

        // Behavioural evaluator: latches DataIn on each Go press, and after
        // the fourth release answers COMPUTE cycles later. ResultValid stays
        // up (stale) until the next transaction's first press.
        always @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                eval_go_q   <= 1'b0;
                eval_n      <= 0;
                eval_cd     <= 0;
                eval_rv     <= 1'b0;
                data_result <= 8'd0;
                eval_cap[0] <= 8'd0;
                eval_cap[1] <= 8'd0;
                eval_cap[2] <= 8'd0;
                eval_cap[3] <= 8'd0;
            end else begin
                eval_go_q <= go;
                if (go && !eval_go_q) begin
                    eval_cap[(eval_n == 4) ? 0 : eval_n] <= data_in;
                    eval_n  <= (eval_n == 4) ? 1 : eval_n + 1;
                    eval_rv <= 1'b0;
                end
                if (!go && eval_go_q && (eval_n == 4) && !eval_mute) begin
                    eval_cd <= COMPUTE;
                end else if (eval_cd != 0) begin
                    eval_cd <= eval_cd - 1;
                    if (eval_cd == 1) begin
                        eval_rv     <= 1'b1;
                        data_result <= poly(eval_cap[0], eval_cap[1], eval_cap[2], eval_cap[3]);
                    end
                end
            end
        end

        // Monitor / scoreboard.
        initial begin
            logic       m_go_q = 1'b0;
            logic       m_done_q = 1'b0;
            logic [7:0] m_din_q = 8'd0;
            logic [7:0] m_rise_din = 8'd0;
            int         high_cnt = 0;
            int         low_cnt = 0;
            int         press_cnt = 0;
            int         since_fall = 1000;
            exp_t       e;
            forever begin
                @(negedge clock);
                if (!resetn) begin
                    m_go_q = 1'b0;
                    m_done_q = 1'b0;
                    m_din_q = 8'd0;
                    press_cnt = 0;
                    high_cnt = 0;
                    low_cnt = 0;
                    since_fall = 1000;
                end else begin
                    since_fall++;
                    if (go && !m_go_q) begin
                        check("go_expected", g, int'(exp_ops.size() != 0), 1);
                        if (exp_ops.size() != 0) begin
                            check("din_order", g, int'(data_in), int'(exp_ops.pop_front()));
                        end
                        check("din_setup", g, int'(m_din_q), int'(data_in));
                        check("busy_in_txn", g, int'(busy), 1);
                        if (press_cnt != 0) begin
                            check("go_low_cycles", g, low_cnt, LG + 1);
                        end
                        press_cnt++;
                        high_cnt = 1;
                        m_rise_din = data_in;
                    end else if (go) begin
                        high_cnt++;
                    end else if (m_go_q) begin
                        check("go_high_cycles", g, high_cnt, LH);
                        check("din_hold", g, int'(data_in), int'(m_rise_din));
                        low_cnt = 1;
                        if (press_cnt == 4) begin
                            since_fall = 0;
                        end
                    end else begin
                        low_cnt++;
                    end

                    if (done) begin
                        check("done_expected", g, int'(exp_q.size() != 0), 1);
                        check("presses_before_done", g, press_cnt, 4);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("result", g, int'(result), int'(e.res));
                            check("error", g, int'(err), int'(e.err));
                            check("done_latency", g, since_fall, e.lat);
                        end
                        press_cnt = 0;
                    end else if (m_done_q) begin
                        check("busy_after_done", g, int'(busy), 0);
                    end
                    m_go_q = go;
                    m_done_q = done;
                    m_din_q = data_in;
                end
            end
        end

        task automatic push_expect(input logic [7:0] ia, input logic [7:0] ib,
                                   input logic [7:0] ic, input logic [7:0] ix,
                                   input logic mute);
            exp_t e;
            exp_ops.push_back(ia);
            exp_ops.push_back(ib);
            exp_ops.push_back(ic);
            exp_ops.push_back(ix);
            if (mute) begin
                e.res = last_res;
                e.err = 1'b1;
                e.lat = LG + LT;
            end else begin
                e.res = poly(ia, ib, ic, ix);
                e.err = 1'b0;
                e.lat = COMPUTE + 2;
                last_res = e.res;
            end
            exp_q.push_back(e);
        endtask

        task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                             input logic [7:0] ic, input logic [7:0] ix,
                             input logic mute);
            a = ia;
            b = ib;
            c = ic;
            x = ix;
            eval_mute = mute;
            push_expect(ia, ib, ic, ix, mute);
            start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            check("error_cleared_on_start", g, int'(err), 0);
        endtask

        task automatic issue_random(input logic mute);
            issue(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), mute);
        endtask

        task automatic wait_empty();
            int n = 0;
            while ((exp_q.size() != 0) && (n < 400)) begin
                @(posedge clock);
                n++;
            end
            check("txn_completed", g, exp_q.size(), 0);
            exp_q.delete();
            exp_ops.delete();
            repeat (3) @(posedge clock);
            #1;
        endtask

        initial begin
            #1 resetn = 1'b0;
            #2;
            check("reset_go", g, int'(go), 0);
            check("reset_datain", g, int'(data_in), 0);
            check("reset_busy", g, int'(busy), 0);
            check("reset_done", g, int'(done), 0);
            check("reset_error", g, int'(err), 0);
            check("reset_result", g, int'(result), 0);
            repeat (2) @(posedge clock);
            #1 resetn = 1'b1;
            repeat (2) @(posedge clock);
            #1;

            issue(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
            wait_empty();
            check("basic_result_27", g, int'(result), 27);

            issue(8'd3, 8'd5, 8'd7, 8'd10, 1'b0);
            wait_empty();
            check("modulo_result_101", g, int'(result), 101);

            for (int i = 0; i < 3; i++) begin
                issue_random(1'b0);
                wait_empty();
            end

            // Silent evaluator: timeout, Result keeps its old value.
            issue_random(1'b1);
            wait_empty();
            check("timeout_error_sticky", g, int'(err), 1);
            issue_random(1'b0);
            wait_empty();

            // Stray ResultValid during the operand phases plus a Start
            // re-pulse with different operands while busy.
            issue_random(1'b0);
            force_rv = 1'b1;
            repeat (3) @(posedge clock);
            #1;
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            x = 8'($urandom);
            start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            repeat (5) @(posedge clock);
            #1 force_rv = 1'b0;
            wait_empty();

            // Start held high across DONE runs a second transaction.
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            x = 8'($urandom);
            eval_mute = 1'b0;
            push_expect(a, b, c, x, 1'b0);
            push_expect(a, b, c, x, 1'b0);
            start = 1'b1;
            repeat (FINAL_FALL + COMPUTE + 2 + 2 + 3) @(posedge clock);
            #1 start = 1'b0;
            wait_empty();

            // Asynchronous reset while operand C is being pressed.
            issue_random(1'b0);
            repeat (2 * PERIOD + 1) @(posedge clock);
            #1;
            check("go_before_reset", g, int'(go), 1);
            resetn = 1'b0;
            #1;
            check("midreset_go", g, int'(go), 0);
            check("midreset_busy", g, int'(busy), 0);
            check("midreset_datain", g, int'(data_in), 0);
            check("midreset_result", g, int'(result), 0);
            check("midreset_done", g, int'(done), 0);
            exp_q.delete();
            exp_ops.delete();
            last_res = 8'd0;
            repeat (2) @(posedge clock);
            #1 resetn = 1'b1;
            repeat (2) @(posedge clock);
            #1;
            issue_random(1'b0);
            wait_empty();
            issue_random(1'b0);
            wait_empty();

            finished = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(lane[0].finished && lane[1].finished) && (n < 50000)) begin
            @(posedge clock);
            n++;
        end
        check("lanes_finished", 0, int'(lane[0].finished && lane[1].finished), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
